// File: rtl/codec_frame_scheduler.sv
// codec_frame_scheduler: per-frame request/collect/mix sequencer feeding one saturated sample to the codec.
module codec_frame_scheduler #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               new_frame,
    output logic               src0_req,
    input  logic               src0_valid,
    input  logic [15:0]        src0_sample,
    input  logic               src1_en,
    output logic               src1_req,
    input  logic               src1_valid,
    input  logic [15:0]        src1_sample,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               frame_overrun,
    output logic [CNT_W-1:0]   underrun_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, MIX} state_t;

    state_t             state;
    logic               use1, got0, got1;
    logic [15:0]        last0, last1;
    logic [TW-1:0]      timer;
    logic               g0, g1, done;
    logic signed [16:0] sum;
    logic [15:0]        sat;

    // Valids arriving this cycle count toward completion, so a same-cycle answer goes straight to MIX.
    always_comb begin
        g0   = got0 | src0_valid;
        g1   = got1 | (use1 & src1_valid);
        done = g0 & (g1 | !use1);
        sum  = {last0[15], last0} + (use1 ? {last1[15], last1} : 17'sd0);
        sat  = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            use1          <= 1'b0;
            got0          <= 1'b0;
            got1          <= 1'b0;
            last0         <= '0;
            last1         <= '0;
            timer         <= '0;
            src0_req      <= 1'b0;
            src1_req      <= 1'b0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            frame_overrun <= 1'b0;
            underrun_cnt  <= '0;
        end else begin
            src0_req      <= 1'b0;
            src1_req      <= 1'b0;
            sample_valid  <= 1'b0;
            frame_overrun <= new_frame & (state != IDLE);
            case (state)
                IDLE: if (new_frame) begin
                    if (enable) begin
                        use1     <= src1_en;
                        src0_req <= 1'b1;
                        src1_req <= src1_en;
                        got0     <= 1'b0;
                        got1     <= 1'b0;
                        timer    <= '0;
                        state    <= WAIT;
                    end else begin
                        sample_out   <= '0;
                        sample_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (src0_valid && !got0) begin
                        last0 <= src0_sample;
                        got0  <= 1'b1;
                    end
                    if (use1 && src1_valid && !got1) begin
                        last1 <= src1_sample;
                        got1  <= 1'b1;
                    end
                    if (done) begin
                        state <= MIX;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        // Missing sources fall back to their last good value.
                        if (!(&underrun_cnt)) underrun_cnt <= underrun_cnt + 1'b1;
                        state <= MIX;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                MIX: begin
                    sample_out   <= sat;
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_codec_frame_scheduler.sv
// tb_codec_frame_scheduler: directed checks of request, mix, saturation, timeout, mute and overrun behaviour.
module tb_codec_frame_scheduler;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic             clk = 0;
    logic             reset_n = 0;
    logic             enable = 0, new_frame = 0, src1_en = 0;
    logic             src0_req, src1_req, src0_valid, src1_valid;
    logic [15:0]      src0_sample, src1_sample, sample_out;
    logic             sample_valid, busy, frame_overrun;
    logic [CNT_W-1:0] underrun_cnt;
    logic             ans0 = 0, ans1 = 0;
    logic [15:0]      val0 = 0, val1 = 0;
    int               n_checks = 0, n_fail = 0, n, cnt;

    always #5 clk = ~clk;

    // Sources answer combinationally during the request cycle.
    assign src0_valid  = src0_req & ans0;
    assign src1_valid  = src1_req & ans1;
    assign src0_sample = val0;
    assign src1_sample = val1;

    codec_frame_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .new_frame(new_frame),
        .src0_req(src0_req), .src0_valid(src0_valid), .src0_sample(src0_sample),
        .src1_en(src1_en), .src1_req(src1_req), .src1_valid(src1_valid), .src1_sample(src1_sample),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .frame_overrun(frame_overrun), .underrun_cnt(underrun_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        new_frame = 1;
        tick();
        new_frame = 0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!sample_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        tick();
        chk("reset_out", sample_out, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cnt", underrun_cnt, 0);
        chk("reset_req", {src0_req, src1_req}, 0);
        reset_n = 1;
        enable = 1;
        ans0 = 1;
        ans1 = 1;
        val0 = 16'h1234;
        tick();

        pulse_frame();
        chk("t1_req0", src0_req, 1);
        chk("t1_req1", src1_req, 0);
        chk("t1_busy", busy, 1);
        wait_valid(n);
        chk("t1_latency", n + 1, 3);
        chk("t1_out", sample_out, 16'h1234);
        chk("t1_cnt", underrun_cnt, 0);
        tick();
        chk("t1_valid_pulse", sample_valid, 0);
        chk("t1_idle", busy, 0);

        src1_en = 1;
        val0 = 16'h7000;
        val1 = 16'h2000;
        pulse_frame();
        chk("t2_req1", src1_req, 1);
        wait_valid(n);
        chk("t2_pos_sat", sample_out, 16'h7FFF);
        tick();
        val0 = 16'h8000;
        val1 = 16'hF000;
        pulse_frame();
        wait_valid(n);
        chk("t2_neg_sat", sample_out, 16'h8000);
        tick();
        val0 = 16'h1000;
        val1 = 16'hFFFF;
        pulse_frame();
        wait_valid(n);
        chk("t2_plain_sum", sample_out, 16'h0FFF);
        tick();

        ans1 = 0;
        val0 = 16'h0100;
        val1 = 16'h5555;
        pulse_frame();
        wait_valid(n);
        chk("t3_latency", n + 1, TIMEOUT + 2);
        chk("t3_last1", sample_out, 16'h00FF);
        chk("t3_cnt", underrun_cnt, 1);
        tick();

        ans1 = 1;
        val0 = 16'h0010;
        val1 = 16'h0020;
        pulse_frame();
        enable = 0;
        wait_valid(n);
        chk("t4_late_mute_out", sample_out, 16'h0030);
        tick();
        pulse_frame();
        chk("t4_mute_req", {src0_req, src1_req}, 0);
        chk("t4_mute_valid", sample_valid, 1);
        chk("t4_mute_out", sample_out, 0);
        chk("t4_mute_busy", busy, 0);
        tick();
        chk("t4_mute_pulse", sample_valid, 0);

        enable = 1;
        ans0 = 0;
        ans1 = 0;
        pulse_frame();
        tick();
        pulse_frame();
        chk("t5_overrun", frame_overrun, 1);
        tick();
        chk("t5_overrun_pulse", frame_overrun, 0);
        wait_valid(n);
        chk("t5_one_valid", sample_valid, 1);
        cnt = 0;
        for (int i = 0; i < 2 * TIMEOUT; i++) begin
            tick();
            if (sample_valid) cnt++;
        end
        chk("t5_no_second_valid", cnt, 0);
        chk("t5_idle", busy, 0);
        chk("t5_cnt", underrun_cnt, 2);
        for (int i = 0; i < 300; i++) begin
            pulse_frame();
            wait_valid(n);
            tick();
        end
        chk("t5_cnt_sat", underrun_cnt, 8'hFF);

        pulse_frame();
        tick();
        tick();
        chk("t6_busy_before", busy, 1);
        reset_n = 0;
        #1;
        chk("t6_async_busy", busy, 0);
        chk("t6_async_out", sample_out, 0);
        chk("t6_async_cnt", underrun_cnt, 0);
        chk("t6_async_req", {src0_req, src1_req, sample_valid, frame_overrun}, 0);
        tick();
        reset_n = 1;
        src1_en = 0;
        ans0 = 1;
        val0 = 16'h1234;
        tick();
        pulse_frame();
        chk("t6_req0", src0_req, 1);
        wait_valid(n);
        chk("t6_latency", n + 1, 3);
        chk("t6_out", sample_out, 16'h1234);
        chk("t6_cnt", underrun_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
